// File: rtl/scores_ram_ctrl_if.sv
// Bus between the scores RAM controller and its clients: compute-engine writes,
// traceback reads, boundary-init control and the registered RAM port signals.
interface scores_ram_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic              start;
  logic              ins_req;
  logic [7:0]        ins_i;
  logic [7:0]        ins_j;
  logic signed [8:0] ins_val;
  logic              ins_ack;
  logic              rd_req;
  logic [7:0]        rd_i;
  logic [7:0]        rd_j;
  logic              rd_ack;
  logic              rd_valid;
  logic              en_din;
  logic              we;
  logic [8:0]        din;
  logic [ADDR_W-1:0] addr_din;
  logic              en_dout;
  logic [ADDR_W-1:0] addr_dout;
  logic              init_done;
  logic              err;

  modport slave (
    input  start, ins_req, ins_i, ins_j, ins_val, rd_req, rd_i, rd_j,
    output ins_ack, rd_ack, rd_valid, en_din, we, din, addr_din,
           en_dout, addr_dout, init_done, err
  );

  modport master (
    output start, ins_req, ins_i, ins_j, ins_val, rd_req, rd_i, rd_j,
    input  ins_ack, rd_ack, rd_valid, en_din, we, din, addr_din,
           en_dout, addr_dout, init_done, err
  );
endinterface

// File: rtl/scores_ram_ctrl.sv
// Score-matrix RAM controller: writes the gap-penalty boundary row/column,
// then arbitrates compute-engine writes and traceback reads onto the RAM ports.
module scores_ram_ctrl #(
  parameter int N      = 128,
  parameter int ADDR_W = $clog2((N + 1) * (N + 1)),
  parameter int GAP    = 1
) (
  input logic             clk,
  input logic             rst,
  scores_ram_ctrl_if.slave bus
);
  localparam int             K_W    = $clog2(N + 1) + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N);
  localparam logic [8:0]     N_L    = 9'(N);

  typedef enum logic [1:0] {IDLE, INIT_ROW, INIT_COL, READY} state_t;

  state_t            state, state_next;
  logic [K_W-1:0]    k, k_next, k_inc;
  logic              stall, stall_next;
  logic              en_din_next, we_next, en_dout_next, rd_valid_next;
  logic              init_done_next, err_next;
  logic [8:0]        din_next;
  logic [ADDR_W-1:0] addr_din_next, addr_dout_next;
  logic [ADDR_W-1:0] ins_addr, rd_addr;
  logic              ready, ins_in_range, rd_in_range, hazard;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] i, input logic [7:0] j);
    return ADDR_W'(32'(i) * (N + 1) + 32'(j));
  endfunction

  // Boundary score -k*GAP, clamped to the most negative 9-bit value.
  function automatic logic [8:0] gap_score(input logic [K_W-1:0] kk);
    int p;
    p = int'(kk) * GAP;
    if (p >= 256) return 9'h100;
    return 9'(-p);
  endfunction

  assign k_inc        = k + 1'b1;
  assign ready        = (state == READY) && !rst;
  assign ins_in_range = (bus.ins_i != 8'd0) && ({1'b0, bus.ins_i} <= N_L) &&
                        (bus.ins_j != 8'd0) && ({1'b0, bus.ins_j} <= N_L);
  assign rd_in_range  = ({1'b0, bus.rd_i} <= N_L) && ({1'b0, bus.rd_j} <= N_L);
  assign ins_addr     = cell_addr(bus.ins_i, bus.ins_j);
  assign rd_addr      = cell_addr(bus.rd_i, bus.rd_j);

  // A restart owns the write port, so a write arriving with start waits for READY again.
  assign bus.ins_ack  = bus.ins_req && ready && !bus.start && ins_in_range;
  assign hazard       = bus.ins_ack && (rd_addr == ins_addr) && !stall;
  assign bus.rd_ack   = bus.rd_req && ready && rd_in_range && !hazard;

  always_comb begin
    state_next     = state;
    k_next         = k;
    stall_next     = 1'b0;
    en_din_next    = 1'b0;
    we_next        = 1'b0;
    din_next       = bus.din;
    addr_din_next  = bus.addr_din;
    en_dout_next   = bus.rd_ack;
    addr_dout_next = bus.rd_ack ? rd_addr : bus.addr_dout;
    rd_valid_next  = bus.en_dout;
    err_next       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next    = INIT_ROW;
          k_next        = '0;
          en_din_next   = 1'b1;
          we_next       = 1'b1;
          addr_din_next = '0;
          din_next      = 9'd0;
        end
      end
      INIT_ROW: begin
        en_din_next = 1'b1;
        we_next     = 1'b1;
        if (k == K_LAST) begin
          state_next    = INIT_COL;
          k_next        = K_W'(1);
          addr_din_next = cell_addr(8'd1, 8'd0);
          din_next      = gap_score(K_W'(1));
        end else begin
          k_next        = k_inc;
          addr_din_next = cell_addr(8'd0, 8'(k_inc));
          din_next      = gap_score(k_inc);
        end
      end
      INIT_COL: begin
        if (k == K_LAST) begin
          state_next = READY;
        end else begin
          k_next        = k_inc;
          en_din_next   = 1'b1;
          we_next       = 1'b1;
          addr_din_next = cell_addr(8'(k_inc), 8'd0);
          din_next      = gap_score(k_inc);
        end
      end
      READY: begin
        err_next = (bus.ins_req && !ins_in_range) || (bus.rd_req && !rd_in_range);
        if (bus.start) begin
          state_next    = INIT_ROW;
          k_next        = '0;
          en_din_next   = 1'b1;
          we_next       = 1'b1;
          addr_din_next = '0;
          din_next      = 9'd0;
        end else if (bus.ins_ack) begin
          en_din_next   = 1'b1;
          we_next       = 1'b1;
          addr_din_next = ins_addr;
          din_next      = bus.ins_val;
        end
        stall_next = bus.rd_req && rd_in_range && hazard;
      end
      default: state_next = IDLE;
    endcase

    init_done_next = (state_next == READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k             <= '0;
      stall         <= 1'b0;
      bus.en_din    <= 1'b0;
      bus.we        <= 1'b0;
      bus.din       <= '0;
      bus.addr_din  <= '0;
      bus.en_dout   <= 1'b0;
      bus.addr_dout <= '0;
      bus.rd_valid  <= 1'b0;
      bus.init_done <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state         <= state_next;
      k             <= k_next;
      stall         <= stall_next;
      bus.en_din    <= en_din_next;
      bus.we        <= we_next;
      bus.din       <= din_next;
      bus.addr_din  <= addr_din_next;
      bus.en_dout   <= en_dout_next;
      bus.addr_dout <= addr_dout_next;
      bus.rd_valid  <= rd_valid_next;
      bus.init_done <= init_done_next;
      bus.err       <= err_next;
    end
  end
endmodule
